mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the pipeline and the single 8-bit RAM port.
- Arbitrates instruction fetch (IF) and load/store (ME) requests, assembles and disassembles 32-bit little-endian words, and returns data with a one-cycle done pulse.
- Drives stall_req_if and stall_req_me straight into the pipeline stall controller.

Parameters:
- RAM_AW, 17: width of the RAM address output; the request address is truncated to its low RAM_AW bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF fetch request, held until if_done
- if_addr  in  32  fetch address, word aligned
- if_rdata  out  32  fetched instruction, valid while if_done=1
- if_done  out  1  one-cycle completion pulse for IF
- me_req  in  1  ME access request, held until me_done
- me_we  in  1  1=store, 0=load
- me_width  in  2  `MEM_B=00 (1 byte), `MEM_H=01 (2 bytes), `MEM_W=10 (4 bytes); 11 is treated as `MEM_W
- me_addr  in  32  byte address
- me_wdata  in  32  store data; bytes taken from bit 0 upward
- me_rdata  out  32  load data, zero-extended, valid while me_done=1
- me_done  out  1  one-cycle completion pulse for ME
- ram_a  out  RAM_AW  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid the cycle after its address was presented
- ram_wr  out  1  RAM write strobe
- stall_req_if  out  1  if_req & ~if_done (combinational)
- stall_req_me  out  1  me_req & ~me_done (combinational)

Behaviour:
- Reset: state IDLE, all counters 0. ram_a=0, ram_dout=0, ram_wr=0, if_done=0, me_done=0, if_rdata=0, me_rdata=0.
- States are IDLE, RD, WR and DONE.
- IDLE:
  - If me_req is high, latch ME. A store goes to WR; a load goes to RD.
  - Otherwise, if if_req is high, latch IF (4-byte read) and go to RD.
  - ME always wins simultaneous requests, because it holds the older instruction.
- Byte count N is 1, 2 or 4. Byte k uses address base+k, with 32-bit wrap-around.
- RD:
  - Cycle k (k=0..N-1) presents ram_a=base+k with ram_wr=0.
  - The byte captured on cycle k+1 goes into bits [8k+7:8k].
  - After the last byte is captured, assert done. Total latency from the acceptance cycle is N+1 cycles to the done pulse.
- WR:
  - Cycle k presents ram_a=base+k, ram_dout=me_wdata[8k+7:8k], ram_wr=1.
  - me_done is pulsed on the cycle after byte N-1. Latency is N+1.
- DONE:
  - Exactly one cycle: done=1 and rdata valid. Then return to IDLE.
  - A request seen during DONE is the already-served one and is ignored. New requests are accepted from the following cycle.
- ram_wr is 1 only in WR. Outside WR, ram_dout holds its last value.
- IF abort:
  - If if_req falls while IF is being served (branch flush), return to IDLE next cycle with no if_done.
  - In-flight read bytes are discarded.
- ME is never aborted. A dropped me_req mid-operation still completes, including the write bytes.
- if_rdata and me_rdata hold their value until the next completion of the same requester.
- Reset mid-operation aborts immediately. No further ram_wr pulses occur.

Optional Feature:
- MEM_CTRL_IF_BUF_EN defined:
  - Adds a one-entry fetch buffer holding a valid bit, an address and an instruction, filled on each IF completion.
  - In IDLE, if if_req hits a valid entry with equal address and no me_req is pending, go straight to DONE. if_done is asserted the next cycle and no RAM access occurs.
  - Any accepted ME store clears the valid bit.
  - Reset clears the valid bit.
- Undefined: every fetch goes to RAM.

Decomposition:
- Defines.v receives:
  - `MEM_B, `MEM_H, `MEM_W
  - the state encodings: `MC_IDLE, `MC_RD, `MC_WR, `MC_DONE
  - the byte-count width
- Optional sub-module mem_ctrl_if_buf holds the fetch buffer. It is instantiated only under MEM_CTRL_IF_BUF_EN.

Test Plan:
- IF fetch, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> ram_a 0x100..0x103 on consecutive cycles; if_done on cycle 5 after acceptance; if_rdata=0x00000513.
- Simultaneous if_req and me_req load, me_width=`MEM_W, me_addr=0x200 -> ME served first, me_done then if_done. stall_req_if stays 1 throughout the ME access.
- Store, me_width=`MEM_H, me_addr=0x301, me_wdata=0xAABBCCDD -> two ram_wr pulses: 0x301<=DD, 0x302<=CC. me_done 3 cycles after acceptance; no write to 0x303.
- Byte load from 0x1FFFF, RAM=0x80 -> me_rdata=0x00000080. Word load at 0xFFFFFFFE wraps to addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- if_req dropped on the second RD cycle -> no if_done. IDLE next cycle; a following me_req is accepted immediately.
- MEM_CTRL_IF_BUF_EN: fetch 0x100 twice -> second fetch gives if_done the next cycle and ram_a does not change. After a store to any address, the third fetch re-reads RAM.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: access widths,
// FSM state encoding, byte-count width and byte-lane helpers.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_RD   = 2'b01,
    MC_WR   = 2'b10,
    MC_DONE = 2'b11
  } mc_state_e;

  // Index of the final byte for an access width; the reserved code 11 acts as a word.
  function automatic logic [CNT_W-1:0] last_index(input logic [1:0] width);
    logic [CNT_W-1:0] idx;
    case (width)
      MEM_B:   idx = 2'd0;
      MEM_H:   idx = 2'd1;
      MEM_W:   idx = 2'd3;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [7:0] data,
                                           input logic [CNT_W-1:0] idx);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = data;
    return w;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [CNT_W-1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if_buf.sv
// One-entry instruction fetch buffer: remembers the last completed fetch
// (address + instruction) so a repeated fetch can skip the RAM.
module mem_ctrl_if_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic        clear,
  input  logic [31:0] addr,
  input  logic [31:0] fill_data,
  output logic        hit,
  output logic [31:0] data
);

  logic        valid;
  logic [31:0] tag;

  // Entry storage; a store anywhere invalidates since it may overwrite code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= 32'd0;
      data  <= 32'd0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= addr;
      data  <= fill_data;
    end
  end

  assign hit = valid && (tag == addr);

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating IF and ME onto one 8-bit RAM port.
// Optional fetch buffer enabled by defining MEM_CTRL_IF_BUF_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              me_req,
  input  logic              me_we,
  input  logic [1:0]        me_width,
  input  logic [31:0]       me_addr,
  input  logic [31:0]       me_wdata,
  output logic [31:0]       me_rdata,
  output logic              me_done,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              ram_wr,
  output logic              stall_req_if,
  output logic              stall_req_me
);

  mc_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, last, last_nxt, cnt_inc;
  logic [RAM_AW-1:0] base, base_nxt, next_addr;
  logic              is_me, is_me_nxt, is_store, is_store_nxt, hit, hit_nxt;
  logic [31:0]       wdata, wdata_nxt, rbuf, rbuf_nxt;
  logic [RAM_AW-1:0] ram_a_nxt;
  logic [7:0]        ram_dout_nxt;
  logic              ram_wr_nxt, if_done_nxt, me_done_nxt;
  logic [31:0]       if_hold, me_hold, done_word;
  logic              buf_hit, buf_fill, buf_clear;
  logic [31:0]       buf_data;

  assign cnt_inc   = cnt + 2'd1;
  // Truncating before the add gives the same low bits as a 32-bit wrapping add.
  assign next_addr = base + {{(RAM_AW-CNT_W){1'b0}}, cnt_inc};

  // Next-state and datapath update for the request FSM.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_nxt     = last;
    base_nxt     = base;
    is_me_nxt    = is_me;
    is_store_nxt = is_store;
    hit_nxt      = hit;
    wdata_nxt    = wdata;
    rbuf_nxt     = rbuf;
    ram_a_nxt    = ram_a;
    ram_dout_nxt = ram_dout;
    ram_wr_nxt   = 1'b0;
    if_done_nxt  = 1'b0;
    me_done_nxt  = 1'b0;
    buf_clear    = 1'b0;
    case (state)
      MC_IDLE: begin
        if (me_req) begin
          is_me_nxt    = 1'b1;
          is_store_nxt = me_we;
          hit_nxt      = 1'b0;
          cnt_nxt      = 2'd0;
          last_nxt     = last_index(me_width);
          base_nxt     = me_addr[RAM_AW-1:0];
          wdata_nxt    = me_wdata;
          rbuf_nxt     = 32'd0;
          ram_a_nxt    = me_addr[RAM_AW-1:0];
          if (me_we) begin
            state_nxt    = MC_WR;
            ram_dout_nxt = me_wdata[7:0];
            ram_wr_nxt   = 1'b1;
            buf_clear    = 1'b1;
          end else begin
            state_nxt = MC_RD;
          end
        end else if (if_req) begin
          is_me_nxt    = 1'b0;
          is_store_nxt = 1'b0;
          cnt_nxt      = 2'd0;
          last_nxt     = 2'd3;
          base_nxt     = if_addr[RAM_AW-1:0];
          rbuf_nxt     = 32'd0;
          if (buf_hit) begin
            state_nxt   = MC_DONE;
            hit_nxt     = 1'b1;
            if_done_nxt = 1'b1;
          end else begin
            state_nxt = MC_RD;
            hit_nxt   = 1'b0;
            ram_a_nxt = if_addr[RAM_AW-1:0];
          end
        end else begin
          state_nxt = MC_IDLE;
        end
      end
      MC_RD: begin
        if (!is_me && !if_req) begin
          state_nxt = MC_IDLE;
        end else begin
          if (cnt != 2'd0) begin
            rbuf_nxt = put_byte(rbuf, ram_din, cnt - 2'd1);
          end else begin
            rbuf_nxt = rbuf;
          end
          if (cnt == last) begin
            state_nxt   = MC_DONE;
            if_done_nxt = !is_me;
            me_done_nxt = is_me;
          end else begin
            cnt_nxt   = cnt_inc;
            ram_a_nxt = next_addr;
          end
        end
      end
      MC_WR: begin
        if (cnt == last) begin
          state_nxt   = MC_DONE;
          me_done_nxt = 1'b1;
        end else begin
          cnt_nxt      = cnt_inc;
          ram_a_nxt    = next_addr;
          ram_dout_nxt = get_byte(wdata, cnt_inc);
          ram_wr_nxt   = 1'b1;
        end
      end
      MC_DONE: begin
        state_nxt = MC_IDLE;
      end
      default: begin
        state_nxt = MC_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MC_IDLE;
      cnt      <= 2'd0;
      last     <= 2'd0;
      base     <= {RAM_AW{1'b0}};
      is_me    <= 1'b0;
      is_store <= 1'b0;
      hit      <= 1'b0;
      wdata    <= 32'd0;
      rbuf     <= 32'd0;
      ram_a    <= {RAM_AW{1'b0}};
      ram_dout <= 8'd0;
      ram_wr   <= 1'b0;
      if_done  <= 1'b0;
      me_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      base     <= base_nxt;
      is_me    <= is_me_nxt;
      is_store <= is_store_nxt;
      hit      <= hit_nxt;
      wdata    <= wdata_nxt;
      rbuf     <= rbuf_nxt;
      ram_a    <= ram_a_nxt;
      ram_dout <= ram_dout_nxt;
      ram_wr   <= ram_wr_nxt;
      if_done  <= if_done_nxt;
      me_done  <= me_done_nxt;
    end
  end

  // The last byte arrives during DONE itself, so it is merged combinationally.
  assign done_word = hit ? buf_data : put_byte(rbuf, ram_din, last);
  assign buf_fill  = (state == MC_DONE) && !is_me;

  // Read data holding registers, updated on each completion of their requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_hold <= 32'd0;
      me_hold <= 32'd0;
    end else if (state == MC_DONE) begin
      if (!is_me) begin
        if_hold <= done_word;
      end else if (!is_store) begin
        me_hold <= done_word;
      end
    end
  end

  assign if_rdata     = if_done ? done_word : if_hold;
  assign me_rdata     = (me_done && !is_store) ? done_word : me_hold;
  assign stall_req_if = if_req & ~if_done;
  assign stall_req_me = me_req & ~me_done;

`ifdef MEM_CTRL_IF_BUF_EN
  mem_ctrl_if_buf u_if_buf (
    .clk       (clk),
    .rst       (rst),
    .fill      (buf_fill),
    .clear     (buf_clear),
    .addr      (if_addr),
    .fill_data (done_word),
    .hit       (buf_hit),
    .data      (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = 32'd0;
`endif

endmodule
